// File: rtl/l2_status_regs.sv
// l2_status_regs -- L2 controller status/bookkeeping registers.
//
// Purpose:
//   Free-MSHR counter with sticky over/underflow error, five set/clear
//   status flags, N_FWD forward-stall channels (flag, captured MSHR entry,
//   "stall ended" flag), and an optional set/way flush walker.
//
// Build option:
//   L2_FLUSH_EN  defined   -> flush walker FSM (IDLE/WALK/DONE) present.
//                undefined -> flush_set/flush_way/ongoing_flush/flush_done
//                             tied low, flush inputs ignored.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   add_mshr_entry              allocate an MSHR (count down)
//   incr_mshr_cnt, mshr_i       free MSHR entry mshr_i (count up)
//   set_<X>/clr_<X>, <X>        flag controls/outputs, X in {evict_stall,
//                               set_conflict, ongoing_fence, ongoing_drain,
//                               ongoing_atomic}
//   set_fwd_stall, clr_fwd_stall, clr_fwd_stall_ended   per-channel controls
//   fwd_stall_entry_data        per-channel entry, MSHR_BITS per channel
//   fwd_stall, fwd_stall_ended, fwd_stall_entry         per-channel state
//   mshr_cnt, mshr_full, mshr_err                       MSHR bookkeeping
//   flush_start/step/abort      flush walker controls
//   flush_set, flush_way, ongoing_flush, flush_done     flush walker state
module l2_status_regs #(
    parameter int  N_MSHR       = 8,
    parameter int  N_FWD        = 2,
    parameter int  N_SETS       = 256,
    parameter int  N_WAYS       = 8,
    localparam int MSHR_BITS    = $clog2(N_MSHR),
    localparam int MSHR_BITS_P1 = $clog2(N_MSHR + 1),
    localparam int SET_BITS     = $clog2(N_SETS),
    localparam int WAY_BITS     = $clog2(N_WAYS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       add_mshr_entry,
    input  logic                       incr_mshr_cnt,
    input  logic [MSHR_BITS-1:0]       mshr_i,
    input  logic                       set_evict_stall,
    input  logic                       clr_evict_stall,
    input  logic                       set_set_conflict,
    input  logic                       clr_set_conflict,
    input  logic                       set_ongoing_fence,
    input  logic                       clr_ongoing_fence,
    input  logic                       set_ongoing_drain,
    input  logic                       clr_ongoing_drain,
    input  logic                       set_ongoing_atomic,
    input  logic                       clr_ongoing_atomic,
    output logic                       evict_stall,
    output logic                       set_conflict,
    output logic                       ongoing_fence,
    output logic                       ongoing_drain,
    output logic                       ongoing_atomic,
    input  logic [N_FWD-1:0]           set_fwd_stall,
    input  logic [N_FWD-1:0]           clr_fwd_stall,
    input  logic [N_FWD-1:0]           clr_fwd_stall_ended,
    input  logic [N_FWD*MSHR_BITS-1:0] fwd_stall_entry_data,
    output logic [N_FWD-1:0]           fwd_stall,
    output logic [N_FWD-1:0]           fwd_stall_ended,
    output logic [N_FWD*MSHR_BITS-1:0] fwd_stall_entry,
    output logic [MSHR_BITS_P1-1:0]    mshr_cnt,
    output logic                       mshr_full,
    output logic                       mshr_err,
    input  logic                       flush_start,
    input  logic                       flush_step,
    input  logic                       flush_abort,
    output logic [SET_BITS-1:0]        flush_set,
    output logic [WAY_BITS-1:0]        flush_way,
    output logic                       ongoing_flush,
    output logic                       flush_done
);

    localparam logic [MSHR_BITS_P1-1:0] MSHR_MAX = MSHR_BITS_P1'(N_MSHR);
    localparam logic [MSHR_BITS_P1-1:0] MSHR_ONE = MSHR_BITS_P1'(1);

    // ------------------------------------------------------------------
    // MSHR free counter
    // ------------------------------------------------------------------
    logic [MSHR_BITS_P1-1:0] mshr_cnt_q, mshr_cnt_d;
    logic                    mshr_err_q, mshr_err_d;

    always_comb begin
        mshr_cnt_d = mshr_cnt_q;
        mshr_err_d = mshr_err_q;
        if (add_mshr_entry && !incr_mshr_cnt) begin
            if (mshr_cnt_q == '0) mshr_err_d = 1'b1;
            else                  mshr_cnt_d = mshr_cnt_q - MSHR_ONE;
        end else if (incr_mshr_cnt && !add_mshr_entry) begin
            if (mshr_cnt_q == MSHR_MAX) mshr_err_d = 1'b1;
            else                        mshr_cnt_d = mshr_cnt_q + MSHR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mshr_cnt_q <= MSHR_MAX;
            mshr_err_q <= 1'b0;
        end else begin
            mshr_cnt_q <= mshr_cnt_d;
            mshr_err_q <= mshr_err_d;
        end
    end

    assign mshr_cnt  = mshr_cnt_q;
    assign mshr_err  = mshr_err_q;
    assign mshr_full = (mshr_cnt_q == '0);

    // ------------------------------------------------------------------
    // Status flags (bit order: evict_stall, set_conflict, ongoing_fence,
    // ongoing_drain, ongoing_atomic); clear wins over set
    // ------------------------------------------------------------------
    logic [4:0] flag_set, flag_clr;
    logic [4:0] flag_q, flag_d;

    assign flag_set = {set_ongoing_atomic, set_ongoing_drain, set_ongoing_fence,
                       set_set_conflict, set_evict_stall};
    assign flag_clr = {clr_ongoing_atomic, clr_ongoing_drain, clr_ongoing_fence,
                       clr_set_conflict, clr_evict_stall};

    always_comb begin
        flag_d = (flag_q | flag_set) & ~flag_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flag_q <= '0;
        else      flag_q <= flag_d;
    end

    assign evict_stall    = flag_q[0];
    assign set_conflict   = flag_q[1];
    assign ongoing_fence  = flag_q[2];
    assign ongoing_drain  = flag_q[3];
    assign ongoing_atomic = flag_q[4];

    // ------------------------------------------------------------------
    // Forward-stall channels
    // ------------------------------------------------------------------
    logic [N_FWD-1:0]           fwd_stall_q, fwd_stall_d;
    logic [N_FWD-1:0]           fwd_ended_q, fwd_ended_d;
    logic [N_FWD*MSHR_BITS-1:0] fwd_entry_q, fwd_entry_d;

    always_comb begin
        fwd_stall_d = fwd_stall_q;
        fwd_ended_d = fwd_ended_q;
        fwd_entry_d = fwd_entry_q;
        for (int unsigned c = 0; c < N_FWD; c++) begin
            if (clr_fwd_stall[c])      fwd_stall_d[c] = 1'b0;
            else if (set_fwd_stall[c]) fwd_stall_d[c] = 1'b1;

            // Entry capture is independent of the clear on the same channel.
            if (set_fwd_stall[c])
                fwd_entry_d[c*MSHR_BITS +: MSHR_BITS] =
                    fwd_stall_entry_data[c*MSHR_BITS +: MSHR_BITS];

            // Match uses the registered stall flag and entry, not this cycle's set.
            if (clr_fwd_stall_ended[c])
                fwd_ended_d[c] = 1'b0;
            else if (incr_mshr_cnt && fwd_stall_q[c] &&
                     (fwd_entry_q[c*MSHR_BITS +: MSHR_BITS] == mshr_i))
                fwd_ended_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_stall_q <= '0;
            fwd_ended_q <= '0;
            fwd_entry_q <= '0;
        end else begin
            fwd_stall_q <= fwd_stall_d;
            fwd_ended_q <= fwd_ended_d;
            fwd_entry_q <= fwd_entry_d;
        end
    end

    assign fwd_stall       = fwd_stall_q;
    assign fwd_stall_ended = fwd_ended_q;
    assign fwd_stall_entry = fwd_entry_q;

    // ------------------------------------------------------------------
    // Flush walker
    // ------------------------------------------------------------------
`ifdef L2_FLUSH_EN
    typedef enum logic [1:0] {
        FL_IDLE,
        FL_WALK,
        FL_DONE
    } flush_state_e;

    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(N_SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(N_WAYS - 1);
    localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);
    localparam logic [WAY_BITS-1:0] WAY_ONE  = WAY_BITS'(1);

    flush_state_e        state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [WAY_BITS-1:0] way_q, way_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FL_IDLE;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        way_d         = way_q;
        ongoing_flush = 1'b0;
        flush_done    = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (flush_start) begin
                    state_d = FL_WALK;
                    set_d   = '0;
                    way_d   = '0;
                end
            end
            FL_WALK: begin
                ongoing_flush = 1'b1;
                if (flush_abort) begin
                    state_d = FL_IDLE;
                end else if (flush_step) begin
                    if (way_q == WAY_LAST) begin
                        way_d = '0;
                        if (set_q == SET_LAST) begin
                            set_d   = '0;
                            state_d = FL_DONE;
                        end else begin
                            set_d = set_q + SET_ONE;
                        end
                    end else begin
                        way_d = way_q + WAY_ONE;
                    end
                end
            end
            FL_DONE: begin
                flush_done = 1'b1;
                state_d    = FL_IDLE;
            end
            default: state_d = FL_IDLE;
        endcase
    end

    assign flush_set = set_q;
    assign flush_way = way_q;
`else
    logic unused_flush;
    assign unused_flush  = flush_start ^ flush_step ^ flush_abort;
    assign flush_set     = '0;
    assign flush_way     = '0;
    assign ongoing_flush = 1'b0;
    assign flush_done    = 1'b0;
`endif

endmodule

// File: doc/l2_status_regs.md
L2_STATUS_REGS -- requirements
Module: l2_status_regs

Interface
REQ-001 Parameter: N_MSHR, 8, MSHR entry count (>=2); MSHR_BITS=$clog2(N_MSHR), MSHR_BITS_P1=$clog2(N_MSHR+1).
REQ-002 Parameter: N_FWD, 2, independent forward-stall channels (>=1).
REQ-003 Parameter: N_SETS, 256, L2 sets (power of two); SET_BITS=$clog2(N_SETS).
REQ-004 Parameter: N_WAYS, 8, L2 ways (power of two); WAY_BITS=$clog2(N_WAYS).
REQ-005 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-low reset.
REQ-007 Port: add_mshr_entry  in  1  MSHR allocate.
REQ-008 Port: incr_mshr_cnt  in  1  MSHR free.
REQ-009 Port: mshr_i  in  MSHR_BITS  index of the entry being freed.
REQ-010 Port: set_X / clr_X  in  1 each  set/clear controls for X in {evict_stall, set_conflict, ongoing_fence, ongoing_drain, ongoing_atomic}.
REQ-011 Port: X  out  1  registered flag for each X above.
REQ-012 Port: set_fwd_stall, clr_fwd_stall, clr_fwd_stall_ended  in  N_FWD  per-channel controls.
REQ-013 Port: fwd_stall_entry_data  in  N_FWD*MSHR_BITS  per-channel entry; channel c at bits [c*MSHR_BITS +: MSHR_BITS].
REQ-014 Port: fwd_stall, fwd_stall_ended  out  N_FWD  per-channel flags.
REQ-015 Port: fwd_stall_entry  out  N_FWD*MSHR_BITS  captured per-channel entries, same packing.
REQ-016 Port: mshr_cnt  out  MSHR_BITS_P1  free MSHR count; mshr_full  out  1  (mshr_cnt==0); mshr_err  out  1  sticky over/underflow.
REQ-017 Port: flush_start, flush_step, flush_abort  in  1  flush walker controls.
REQ-018 Port: flush_set  out  SET_BITS; flush_way  out  WAY_BITS; ongoing_flush  out  1; flush_done  out  1.

Function
REQ-019 mshr_cnt: add only -> -1; incr only -> +1; both in same cycle -> unchanged.
REQ-020 add only with mshr_cnt==0, or incr only with mshr_cnt==N_MSHR -> count held, mshr_err set; mshr_err clears only on reset.
REQ-021 mshr_full is combinational from mshr_cnt; all other outputs are registered with one-cycle latency.
REQ-022 Each flag X and each fwd_stall[c]: clr has priority over set; neither asserted -> hold.
REQ-023 set_fwd_stall[c] loads fwd_stall_entry[c] from its data slice in that cycle, regardless of clr_fwd_stall[c]; entry otherwise holds.
REQ-024 fwd_stall_ended[c] sets when incr_mshr_cnt && fwd_stall[c] && fwd_stall_entry[c]==mshr_i, using registered values; clr_fwd_stall_ended[c] has priority; several channels may set in the same cycle.
REQ-025 Flush FSM states IDLE, WALK, DONE; flush_start honoured only in IDLE: -> WALK, flush_set=0, flush_way=0.
REQ-026 WALK: flush_step increments flush_way; at flush_way==N_WAYS-1 the way wraps to 0 and flush_set increments.
REQ-027 WALK with flush_step at set N_SETS-1, way N_WAYS-1 -> DONE; counters wrap to 0.
REQ-028 DONE: flush_done high exactly one cycle, then -> IDLE unconditionally.
REQ-029 flush_abort in WALK -> IDLE next cycle, counters hold, no flush_done; abort has priority over step.
REQ-030 ongoing_flush is high iff state is WALK.

Reset
REQ-031 On rst low: mshr_cnt=N_MSHR, mshr_err=0, all flags=0, fwd_stall_entry=0, FSM=IDLE, flush_set=0, flush_way=0, flush_done=0, asynchronously, including mid-walk.

Configuration
REQ-032 Macro L2_FLUSH_EN: defined -> flush walker per REQ-025..030; undefined -> no FSM, flush_set/flush_way/ongoing_flush/flush_done tied 0, flush inputs ignored.

Verification
REQ-033 N_MSHR=8: 8 adds -> mshr_cnt 0, mshr_full=1; 9th add -> mshr_cnt stays 0, mshr_err=1.
REQ-034 mshr_cnt=5, add and incr same cycle -> mshr_cnt stays 5, mshr_err=0.
REQ-035 set_fwd_stall[1] with entry 3, then incr_mshr_cnt with mshr_i=3 -> fwd_stall_ended[1]=1 next cycle, fwd_stall_ended[0]=0.
REQ-036 set_ongoing_atomic and clr_ongoing_atomic same cycle -> ongoing_atomic=0.
REQ-037 L2_FLUSH_EN, N_SETS=4, N_WAYS=2: flush_start then 8 steps -> (set,way) 0,1 1,0 ... 3,1, then DONE; flush_done pulses one cycle, ongoing_flush=0.
REQ-038 Abort at set 2 way 1 -> IDLE, no flush_done; rst low mid-walk -> all outputs at reset values immediately.
